// File: rtl/evm_pkg.sv
// Shared types for the EVM ballot path: candidate codes, ballot FSM states
// and small helpers for decoding the four-button bus (bit 0 = BJP .. bit 3 = INC).
package evm_pkg;

  typedef enum logic [1:0] {
    CAND_BJP = 2'd0,
    CAND_JDU = 2'd1,
    CAND_RJD = 2'd2,
    CAND_INC = 2'd3
  } candidate_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_DEBOUNCE = 3'd2,
    ST_SEND     = 3'd3,
    ST_CONFIRM  = 3'd4,
    ST_RELEASE  = 3'd5
  } ballot_state_e;

  localparam int unsigned NUM_BUTTONS = 4;
  localparam int unsigned CNT_W       = 8;

  function automatic logic [NUM_BUTTONS-1:0] cand_mask(input candidate_e c);
    return 4'b0001 << c;
  endfunction

  function automatic logic is_single(input logic [NUM_BUTTONS-1:0] b);
    return (b != 4'b0000) && ((b & (b - 4'd1)) == 4'b0000);
  endfunction

  function automatic candidate_e cand_encode(input logic [NUM_BUTTONS-1:0] b);
    candidate_e c;
    case (b)
      4'b0010: c = CAND_JDU;
      4'b0100: c = CAND_RJD;
      4'b1000: c = CAND_INC;
      default: c = CAND_BJP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/evm_btn_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous button inputs.
module evm_btn_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/evm_ballot_unit.sv
// Ballot unit: one authorised, debounced single-candidate vote per ballot_issue,
// handed to the tally over valid/ready, then lamp confirmation and release wait.
module evm_ballot_unit
  import evm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CONFIRM_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ballot_issue,
  input  logic       button_bjp,
  input  logic       button_jdu,
  input  logic       button_rjd,
  input  logic       button_inc,
  output logic       vote_valid,
  output logic [1:0] vote_code,
  input  logic       vote_ready,
  output logic       ready_led,
  output logic       led_bjp,
  output logic       led_jdu,
  output logic       led_rjd,
  output logic       led_inc,
  output logic       multi_err
);

  localparam logic [CNT_W-1:0] DEB_LIMIT  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CONF_LIMIT = CNT_W'(CONFIRM_CYCLES);

  logic [NUM_BUTTONS-1:0] btn_raw;
  logic [NUM_BUTTONS-1:0] btn_sync;

  ballot_state_e          state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  candidate_e             code_q, code_d;
  logic                   vote_valid_q, vote_valid_d;
  candidate_e             vote_code_q, vote_code_d;
  logic                   ready_led_q, ready_led_d;
  logic [NUM_BUTTONS-1:0] led_q, led_d;
  logic                   multi_err_q, multi_err_d;

  logic                   single_press;
  logic                   multi_press;

  assign btn_raw = {button_inc, button_rjd, button_jdu, button_bjp};

  evm_btn_sync #(
    .WIDTH(NUM_BUTTONS)
  ) u_btn_sync (
    .clk  (clk),
    .rst_n(rst),
    .d    (btn_raw),
    .q    (btn_sync)
  );

  assign single_press = is_single(btn_sync);
  assign multi_press  = (btn_sync != '0) && !single_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      code_q       <= CAND_BJP;
      vote_valid_q <= 1'b0;
      vote_code_q  <= CAND_BJP;
      ready_led_q  <= 1'b0;
      led_q        <= '0;
      multi_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      vote_valid_q <= vote_valid_d;
      vote_code_q  <= vote_code_d;
      ready_led_q  <= ready_led_d;
      led_q        <= led_d;
      multi_err_q  <= multi_err_d;
    end
  end

  // Outputs are derived from the next state so every output leaves a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    code_d      = code_q;
    multi_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (ballot_issue) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (single_press) begin
          state_d = ST_DEBOUNCE;
          code_d  = cand_encode(btn_sync);
          cnt_d   = 8'd1;
        end else if (multi_press) begin
          multi_err_d = 1'b1;
        end
      end
      ST_DEBOUNCE: begin
        if (btn_sync == cand_mask(code_q)) begin
          if (cnt_q >= DEB_LIMIT) begin
            state_d = ST_SEND;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else begin
          state_d     = ST_ARMED;
          cnt_d       = '0;
          multi_err_d = multi_press;
        end
      end
      ST_SEND: begin
        if (vote_ready) begin
          state_d = ST_CONFIRM;
          cnt_d   = 8'd1;
        end
      end
      ST_CONFIRM: begin
        if (cnt_q >= CONF_LIMIT) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RELEASE: begin
        if (btn_sync == '0) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    vote_valid_d = (state_d == ST_SEND);
    vote_code_d  = (state_d == ST_SEND) ? code_d : CAND_BJP;
    ready_led_d  = (state_d == ST_ARMED);
    led_d        = (state_d == ST_CONFIRM) ? cand_mask(code_d) : '0;
  end

  assign vote_valid = vote_valid_q;
  assign vote_code  = vote_code_q;
  assign ready_led  = ready_led_q;
  assign led_bjp    = led_q[0];
  assign led_jdu    = led_q[1];
  assign led_rjd    = led_q[2];
  assign led_inc    = led_q[3];
  assign multi_err  = multi_err_q;

endmodule

// File: tb/tb_evm_ballot_unit.sv
// Self-checking bench for evm_ballot_unit: directed scenarios plus randomized
// votes, checked against a transaction-level scoreboard of expected votes.
module tb_evm_ballot_unit;

  localparam int DEB  = 4;
  localparam int CONF = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       ballot_issue;
  logic       button_bjp, button_jdu, button_rjd, button_inc;
  logic       vote_valid;
  logic [1:0] vote_code;
  logic       vote_ready;
  logic       ready_led;
  logic       led_bjp, led_jdu, led_rjd, led_inc;
  logic       multi_err;

  int checkCount = 0;
  int passCount  = 0;
  int validRises = 0;
  int multiErrs  = 0;
  int readyHigh  = 0;
  logic prevValid = 1'b0;
  int expQ[$];

  evm_ballot_unit #(
    .DEBOUNCE_CYCLES(DEB),
    .CONFIRM_CYCLES (CONF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ballot_issue(ballot_issue),
    .button_bjp  (button_bjp),
    .button_jdu  (button_jdu),
    .button_rjd  (button_rjd),
    .button_inc  (button_inc),
    .vote_valid  (vote_valid),
    .vote_code   (vote_code),
    .vote_ready  (vote_ready),
    .ready_led   (ready_led),
    .led_bjp     (led_bjp),
    .led_jdu     (led_jdu),
    .led_rjd     (led_rjd),
    .led_inc     (led_inc),
    .multi_err   (multi_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic issue, input logic [3:0] btns, input logic ready);
    ballot_issue = issue;
    {button_inc, button_rjd, button_jdu, button_bjp} = btns;
    vote_ready = ready;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ledVec();
    return {led_inc, led_rjd, led_jdu, led_bjp};
  endfunction

  // Scoreboard: every completed handshake must match the oldest expected vote.
  always @(negedge clk) begin
    if (rst) begin
      if (vote_valid && !prevValid) validRises++;
      prevValid = vote_valid;
      if (multi_err) multiErrs++;
      if (ready_led) readyHigh++;
      if (vote_valid && vote_ready) begin
        checkOutput("transfer_expected", (expQ.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (expQ.size() > 0) checkOutput("vote_code_xfer", {30'd0, vote_code}, expQ.pop_front());
      end
    end else begin
      prevValid = 1'b0;
    end
  end

  task automatic issueBallot();
    ballot_issue = 1'b1;
    tick();
    ballot_issue = 1'b0;
    checkOutput("ready_led_armed", {31'd0, ready_led}, 32'd1);
  endtask

  // Unit must be armed; presses cand and expects exactly one vote through.
  task automatic pressVote(input int cand, input int extraHold, input int readyDelay, input bit ballotDuringSend);
    int   rises0 = validRises;
    int   lat = 0;
    int   ledCount;
    logic stableOk = 1'b1;
    logic otherOk = 1'b1;
    logic [3:0] oneHot = 4'b0001 << cand;
    applyStimulus(1'b0, oneHot, 1'b0);
    for (int k = 1; k <= DEB + 10 && lat == 0; k++) begin
      tick();
      if (vote_valid) lat = k;
    end
    checkOutput("latency", lat, DEB + 3);
    checkOutput("vote_code_send", {30'd0, vote_code}, cand);
    for (int r = 0; r < readyDelay; r++) begin
      if (ballotDuringSend && r == 0) ballot_issue = 1'b1;
      tick();
      ballot_issue = 1'b0;
      if (!(vote_valid === 1'b1 && vote_code === 2'(cand))) stableOk = 1'b0;
    end
    checkOutput("send_stable", {31'd0, stableOk}, 32'd1);
    expQ.push_back(cand);
    vote_ready = 1'b1;
    tick();
    vote_ready = 1'b0;
    checkOutput("valid_drop", {31'd0, vote_valid}, 32'd0);
    ledCount = (ledVec() == oneHot) ? 1 : 0;
    for (int i = 1; i < CONF + 4; i++) begin
      tick();
      if (ledVec() == oneHot) ledCount++;
      if ((ledVec() & ~oneHot) != 4'b0000) otherOk = 1'b0;
    end
    checkOutput("led_cycles", ledCount, CONF);
    checkOutput("other_leds_off", {31'd0, otherOk}, 32'd1);
    repeat (extraHold) tick();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    repeat (4) tick();
    checkOutput("single_vote", validRises - rises0, 1);
    checkOutput("idle_ready_led", {31'd0, ready_led}, 32'd0);
  endtask

  // Press a button with no ballot authorised; nothing may happen.
  task automatic pressIgnored(input logic [3:0] btns, input int len);
    int rises0 = validRises;
    int ready0 = readyHigh;
    applyStimulus(1'b0, btns, 1'b0);
    repeat (len) tick();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    repeat (4) tick();
    checkOutput("no_ballot_no_vote", validRises - rises0, 0);
    checkOutput("no_ballot_ready_led", readyHigh - ready0, 0);
  endtask

  initial begin
    int rises0;
    int multi0;
    int cand;
    int glitchLen;
    int dly;
    bit extraBallot;
    logic [3:0] pairMask;

    rst = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0);
    repeat (3) tick();
    checkOutput("reset_outputs", {vote_valid, vote_code, ready_led, ledVec(), multi_err}, 0);
    @(negedge clk) rst = 1'b1;
    tick();

    pressIgnored(4'b1000, 20);

    issueBallot();
    pressVote(1, 2, 0, 1'b0);

    // Two buttons together: error pulses, no vote, unit stays armed.
    issueBallot();
    rises0 = validRises;
    multi0 = multiErrs;
    applyStimulus(1'b0, 4'b1001, 1'b0);
    repeat (10) tick();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    repeat (4) tick();
    checkOutput("multi_err_seen", (multiErrs > multi0) ? 32'd1 : 32'd0, 32'd1);
    checkOutput("multi_no_vote", validRises - rises0, 0);
    checkOutput("multi_still_armed", {31'd0, ready_led}, 32'd1);
    pressVote(2, 0, 1, 1'b0);

    // Glitch shorter than the debounce window must not vote.
    issueBallot();
    glitchLen = $urandom_range(1, DEB);
    rises0 = validRises;
    applyStimulus(1'b0, 4'b0001, 1'b0);
    repeat (glitchLen) tick();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    repeat (12) tick();
    checkOutput("glitch_no_vote", validRises - rises0, 0);
    checkOutput("glitch_still_armed", {31'd0, ready_led}, 32'd1);
    pressVote(0, 0, 0, 1'b0);

    issueBallot();
    pressVote(3, 20, 5, 1'b0);

    // Reset while a vote is pending drops it.
    issueBallot();
    applyStimulus(1'b0, 4'b0100, 1'b0);
    repeat (DEB + 3) tick();
    checkOutput("pre_reset_valid", {31'd0, vote_valid}, 32'd1);
    #2 rst = 1'b0;
    #1 checkOutput("reset_mid_send", {vote_valid, vote_code, ready_led, ledVec(), multi_err}, 0);
    @(negedge clk) rst = 1'b1;
    tick();
    rises0 = validRises;
    repeat (20) tick();
    applyStimulus(1'b0, 4'b0000, 1'b0);
    repeat (4) tick();
    checkOutput("post_reset_no_vote", validRises - rises0, 0);
    issueBallot();
    pressVote(2, 1, 2, 1'b0);

    for (int n = 0; n < 6; n++) begin
      cand = $urandom_range(0, 3);
      extraBallot = 1'($urandom_range(0, 1));
      dly = $urandom_range(extraBallot ? 1 : 0, 5);
      issueBallot();
      pressVote(cand, $urandom_range(0, 15), dly, extraBallot);
      if (extraBallot) pressIgnored(4'b0001 << $urandom_range(0, 3), 12);
    end

    pairMask = 4'b0110;
    pressIgnored(pairMask, 8);

    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/evm_ballot_unit.md
EVM_BALLOT_UNIT -- requirements
Module: evm_ballot_unit

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: cycles a synchronized single-button code SHALL stay stable before acceptance (range 1..255).
REQ-002 Parameter CONFIRM_CYCLES, default 8: cycles the confirmation LED SHALL stay lit after a vote is accepted (range 1..255).
REQ-003 clk  input  1  sole clock, all state rising-edge.
REQ-004 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 ballot_issue  input  1  one-cycle pulse from control unit authorising exactly one vote.
REQ-006 button_bjp, button_jdu, button_rjd, button_inc  input  1 each  asynchronous raw candidate buttons, active-high.
REQ-007 vote_valid  output  1  vote offered to tally unit.
REQ-008 vote_code  output  2  candidate: 0=BJP, 1=JDU, 2=RJD, 3=INC.
REQ-009 vote_ready  input  1  tally unit accepts the vote when high with vote_valid.
REQ-010 ready_led  output  1  high while unit is armed and waiting for a press.
REQ-011 led_bjp, led_jdu, led_rjd, led_inc  output  1 each  vote confirmation lamps.
REQ-012 multi_err  output  1  one-cycle pulse when more than one button is seen pressed.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer; all FSM decisions SHALL use synchronized values only.
REQ-014 FSM states SHALL be IDLE, ARMED, DEBOUNCE, SEND, CONFIRM, RELEASE.
REQ-015 IDLE: buttons ignored; ballot_issue=1 -> ARMED next cycle.
REQ-016 ARMED: ready_led=1; exactly one synchronized button high -> DEBOUNCE, capture its code, counter=1; more than one high -> multi_err pulse, stay ARMED.
REQ-017 DEBOUNCE: same single button still high -> counter+1; counter reaching DEBOUNCE_CYCLES -> SEND; any other pattern (release, different or extra button) -> ARMED, counter cleared, multi_err pulsed if more than one high.
REQ-018 SEND: vote_valid=1, vote_code=captured code, both stable until the cycle vote_ready=1; transfer completes on that edge -> CONFIRM.
REQ-019 vote_valid SHALL NOT depend combinationally on vote_ready; vote_ready while not in SEND is ignored.
REQ-020 CONFIRM: LED matching the captured code high for exactly CONFIRM_CYCLES cycles, others low -> RELEASE.
REQ-021 RELEASE: wait until all synchronized buttons low for one cycle -> IDLE; prevents a held button voting twice.
REQ-022 ballot_issue outside IDLE SHALL be ignored (no queuing); exactly one vote per accepted ballot_issue.
REQ-023 Minimum latency, single clean press: vote_valid rises DEBOUNCE_CYCLES+3 edges after raw button rises (2 sync + 1 ARMED detect + DEBOUNCE_CYCLES-1 count + 1 to SEND).
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, counters 0, captured code 0, synchronizers 0, vote_valid=0, vote_code=0, ready_led=0, all LEDs 0, multi_err=0.
REQ-026 Reset during SEND SHALL drop the pending vote; no vote_valid after rst returns high until a new ballot_issue.
REQ-027 Deassertion SHALL take effect on the first rising clk edge with rst=1.

Structure
REQ-028 Shared package evm_pkg SHALL hold candidate enum (BJP, JDU, RJD, INC, 2 bits) and ballot FSM state enum; the tally module uses the same candidate enum.
REQ-029 One sub-module evm_btn_sync (parameterised-width 2-flop synchronizer, async active-low reset) SHALL be instantiated for the four buttons.

Verification (DEBOUNCE_CYCLES=4, CONFIRM_CYCLES=8)
REQ-030 ballot_issue, hold button_jdu 10 cycles, vote_ready=1 -> vote_valid rises 7 edges after press, vote_code=1, one transfer, led_jdu high 8 cycles, then IDLE after release.
REQ-031 ballot_issue, button_bjp and button_inc together -> multi_err pulses, no vote_valid; then button_rjd alone -> vote_code=2 transferred.
REQ-032 button_inc with no ballot_issue for 20 cycles -> vote_valid stays 0, ready_led 0.
REQ-033 ballot_issue, button_bjp glitch 2 cycles then low -> no vote; later 6-cycle press -> vote_code=0.
REQ-034 vote_ready held low 5 cycles in SEND -> vote_valid and vote_code=3 stable throughout, single transfer when ready rises; holding button_inc past CONFIRM gives no second vote.
REQ-035 rst=0 mid-SEND -> all outputs 0 immediately; after release no vote until new ballot_issue.
